// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_loader_pkg
// Purpose  : Shared types, default marker and word-count helpers for the loader.
// Revision : 1.0
// ============================================================================
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MARKER = 3'd1,
        ST_FETCH  = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam int         c_DEFAULT_MARKER_LEN = 8;
    localparam logic [7:0] c_DEFAULT_MARKER     = 8'hA5;

    function automatic int words_needed(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // A zero remainder means the final word is consumed in full.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ccff_word_serializer
// Purpose  : Holds one configuration word and hands it out LSB-first.
// Revision : 1.0
// ============================================================================
module ccff_word_serializer #(
    parameter  int WORD_W = 32,
    localparam int NB_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic [NB_W-1:0]   nbits,
    input  logic              shift,
    output logic              bit_out,
    output logic              empty
);

    logic [WORD_W-1:0] r_sr;
    logic [NB_W-1:0]   r_left;

    // load together with shift means bit 0 was consumed directly from the word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr   <= '0;
            r_left <= '0;
        end else if (load) begin
            r_sr   <= shift ? (word >> 1) : word;
            r_left <= shift ? (nbits - NB_W'(1)) : nbits;
        end else if (shift && (r_left != '0)) begin
            r_sr   <= r_sr >> 1;
            r_left <= r_left - NB_W'(1);
        end
    end

    assign bit_out = r_sr[0];
    assign empty   = (r_left == '0);

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Streams a marker plus configuration words into a ccff chain and
//            verifies the marker as it emerges at the tail.
// Revision : 1.0
// ============================================================================
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter  int                    CHAIN_LEN  = 1024,
    parameter  int                    WORD_W     = 32,
    parameter  int                    MARKER_LEN = c_DEFAULT_MARKER_LEN,
    parameter  logic [MARKER_LEN-1:0] MARKER     = c_DEFAULT_MARKER,
    localparam int                    CNT_W      = $clog2(CHAIN_LEN + MARKER_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  shift_count
);

    localparam int c_WORDS = words_needed(CHAIN_LEN, WORD_W);
    localparam int c_WC_W  = $clog2(c_WORDS + 1);
    localparam int c_NB_W  = $clog2(WORD_W + 1);
    localparam int c_MK_IW = $clog2(MARKER_LEN);

    localparam logic [c_NB_W-1:0] c_FULL_BITS  = c_NB_W'(WORD_W);
    localparam logic [c_NB_W-1:0] c_LAST_BITS  = c_NB_W'(last_word_bits(CHAIN_LEN, WORD_W));
    localparam logic [c_WC_W-1:0] c_LAST_WORD  = c_WC_W'(c_WORDS - 1);
    localparam logic [CNT_W-1:0]  c_MK_LAST    = CNT_W'(MARKER_LEN - 1);
    localparam logic [CNT_W-1:0]  c_CHK_FIRST  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  c_LAST_SHIFT = CNT_W'(CHAIN_LEN + MARKER_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_head;
    logic                r_shift_en;
    logic                r_mismatch;
    logic [CNT_W-1:0]    r_count;
    logic [c_WC_W-1:0]   r_words;

    logic                w_head_nxt;
    logic                w_shift_en_nxt;
    logic                w_clear;
    logic                w_ser_load;
    logic                w_ser_shift;
    logic                w_ser_bit;
    logic                w_ser_empty;
    logic                w_chk_fail;
    logic                w_mismatch_now;
    logic [c_MK_IW-1:0]  w_mk_chk_idx;
    logic [c_MK_IW-1:0]  w_mk_next_idx;
    logic [c_NB_W-1:0]   w_nbits;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk     (prog_clk),
        .rst     (prog_reset),
        .load    (w_ser_load),
        .word    (cfg_data),
        .nbits   (w_nbits),
        .shift   (w_ser_shift),
        .bit_out (w_ser_bit),
        .empty   (w_ser_empty)
    );

    // The marker leaves the tail during the final MARKER_LEN shifts of a load.
    assign w_mk_chk_idx   = c_MK_IW'(r_count - c_CHK_FIRST);
    assign w_mk_next_idx  = c_MK_IW'(r_count + CNT_W'(1));
    assign w_chk_fail     = r_shift_en && (r_count >= c_CHK_FIRST) && (r_count <= c_LAST_SHIFT)
                            && (ccff_tail != MARKER[w_mk_chk_idx]);
    assign w_mismatch_now = r_mismatch || w_chk_fail;
    assign w_nbits        = (r_words == c_LAST_WORD) ? c_LAST_BITS : c_FULL_BITS;

    always_comb begin
        w_state_nxt    = r_state;
        w_head_nxt     = 1'b0;
        w_shift_en_nxt = 1'b0;
        w_clear        = 1'b0;
        w_ser_load     = 1'b0;
        w_ser_shift    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start && !abort) begin
                    w_clear        = 1'b1;
                    w_state_nxt    = ST_MARKER;
                    w_shift_en_nxt = 1'b1;
                    w_head_nxt     = MARKER[0];
                end
            end
            ST_MARKER: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count == c_MK_LAST) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_shift_en_nxt = 1'b1;
                    w_head_nxt     = MARKER[w_mk_next_idx];
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (cfg_valid) begin
                    w_ser_load     = 1'b1;
                    w_ser_shift    = 1'b1;
                    w_shift_en_nxt = 1'b1;
                    w_head_nxt     = cfg_data[0];
                    w_state_nxt    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count == c_LAST_SHIFT) begin
                    w_state_nxt = w_mismatch_now ? ST_ERROR : ST_DONE;
                end else if (w_ser_empty) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_ser_shift    = 1'b1;
                    w_shift_en_nxt = 1'b1;
                    w_head_nxt     = w_ser_bit;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_state    <= ST_IDLE;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            r_count    <= '0;
            r_mismatch <= 1'b0;
            r_words    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_shift_en <= w_shift_en_nxt;
            if (w_clear)
                r_count <= '0;
            else if (r_shift_en)
                r_count <= r_count + CNT_W'(1);
            if (w_clear)
                r_mismatch <= 1'b0;
            else if (w_chk_fail)
                r_mismatch <= 1'b1;
            if (w_clear)
                r_words <= '0;
            else if (w_ser_load)
                r_words <= r_words + c_WC_W'(1);
        end
    end

    assign cfg_ready     = (r_state == ST_FETCH) && !abort;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign shift_count   = r_count;
    assign busy          = (r_state == ST_MARKER) || (r_state == ST_FETCH) || (r_state == ST_SHIFT);
    assign done          = (r_state == ST_DONE);
    assign error         = (r_state == ST_ERROR);
    assign isol_n        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Purpose  : Directed bench with a behavioural chain and a head-bit scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ccff_chain_loader;

    localparam int         CL = 40;
    localparam int         WW = 16;
    localparam int         ML = 8;
    localparam logic [7:0] MK = 8'hA5;
    localparam int         CW = $clog2(CL + ML + 1);
    localparam logic [CL-1:0] EXP_PAYLOAD = 40'hCD_BEEF_1234;

    logic          prog_clk;
    logic          prog_reset;
    logic          start;
    logic          abort;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          isol_n;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] shift_count;

    logic [CL-1:0] chain;
    logic          force_zero;
    logic          mon_en;
    logic          exp_q[$];
    int            tests;
    int            fails;

    ccff_chain_loader #(
        .CHAIN_LEN  (CL),
        .WORD_W     (WW),
        .MARKER_LEN (ML),
        .MARKER     (MK)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .isol_n        (isol_n),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .shift_count   (shift_count)
    );

    always #5 prog_clk = ~prog_clk;

    // Head enters at bit 0, tail is the MSB.
    always @(posedge prog_clk) begin
        if (ccff_shift_en)
            chain <= {chain[CL-2:0], ccff_head};
    end
    assign ccff_tail = force_zero ? 1'b0 : chain[CL-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge prog_clk) begin
        if (mon_en && ccff_shift_en) begin
            if (exp_q.size() == 0) begin
                chk("head_q_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
                logic e;
                e = exp_q.pop_front();
                chk("head_bit", 64'(ccff_head), 64'(e));
            end
        end
    end

    // The first-shifted payload bit ends at the tail, so reverse to payload order.
    function automatic logic [CL-1:0] payload_view(input logic [CL-1:0] c);
        logic [CL-1:0] r;
        for (int i = 0; i < CL; i++)
            r[i] = c[CL-1-i];
        return r;
    endfunction

    task automatic do_start();
        @(negedge prog_clk);
        start = 1'b1;
        for (int i = 0; i < ML; i++)
            exp_q.push_back(MK[i]);
        @(negedge prog_clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int nb, input int stall);
        for (int i = 0; i < 100 && !cfg_ready; i++)
            @(negedge prog_clk);
        chk("fetch_reached", 64'(cfg_ready), 64'd1);
        for (int s = 0; s < stall; s++) begin
            chk("stall_shift_en", 64'(ccff_shift_en), 64'd0);
            chk("stall_ready", 64'(cfg_ready), 64'd1);
            @(negedge prog_clk);
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int b = 0; b < nb; b++)
            exp_q.push_back(w[b]);
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        cfg_data  = 16'hDEAD;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++)
            @(negedge prog_clk);
        chk("load_finished", 64'(busy), 64'd0);
    endtask

    task automatic check_end(input logic exp_done, input logic exp_err);
        chk("end_done", 64'(done), 64'(exp_done));
        chk("end_error", 64'(error), 64'(exp_err));
        chk("end_isol_n", 64'(isol_n), 64'(exp_done));
        chk("end_shift_count", 64'(shift_count), 64'(CL + ML));
        chk("end_shift_en", 64'(ccff_shift_en), 64'd0);
        chk("end_q_drained", 64'(exp_q.size()), 64'd0);
        chk("end_chain", 64'(payload_view(chain)), 64'(EXP_PAYLOAD));
    endtask

    task automatic run_load(input int stall, input logic [WW-1:0] w2, input logic exp_done);
        do_start();
        send_word(16'h1234, WW, stall);
        send_word(16'hBEEF, WW, stall);
        send_word(w2, CL % WW, stall);
        wait_idle(300);
        check_end(exp_done, !exp_done);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
        chk({tag, "_head"}, 64'(ccff_head), 64'd0);
        chk({tag, "_shift_en"}, 64'(ccff_shift_en), 64'd0);
        chk({tag, "_isol_n"}, 64'(isol_n), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_shift_count"}, 64'(shift_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] held;
        tests      = 0;
        fails      = 0;
        prog_clk   = 1'b0;
        prog_reset = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        force_zero = 1'b0;
        mon_en     = 1'b0;
        chain      = '0;

        #12;
        check_all_zero("reset");
        @(negedge prog_clk);
        prog_reset = 1'b0;
        mon_en     = 1'b1;

        // Nominal load
        run_load(0, 16'h00CD, 1'b1);

        // Broken chain: marker never returns
        force_zero = 1'b1;
        run_load(0, 16'h00CD, 1'b0);
        force_zero = 1'b0;

        // Producer stalls before every word
        run_load(5, 16'h00CD, 1'b1);

        // Upper byte of the last word must be discarded
        run_load(0, 16'hFFCD, 1'b1);

        // Abort mid-payload, then a clean restart
        do_start();
        send_word(16'h1234, WW, 0);
        for (int i = 0; i < 200 && shift_count != CW'(20); i++)
            @(negedge prog_clk);
        chk("abort_point", 64'(shift_count), 64'd20);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_error", 64'(error), 64'd0);
        chk("abort_isol_n", 64'(isol_n), 64'd0);
        chk("abort_shift_en", 64'(ccff_shift_en), 64'd0);
        chk("abort_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("abort_count", 64'(shift_count), 64'd21);
        repeat (3) @(negedge prog_clk);
        chk("abort_count_hold", 64'(shift_count), 64'd21);
        exp_q.delete();
        run_load(0, 16'h00CD, 1'b1);

        // Asynchronous reset in the middle of SHIFT
        do_start();
        send_word(16'h1234, WW, 0);
        send_word(16'hBEEF, WW, 0);
        for (int i = 0; i < 200 && shift_count != CW'(30); i++)
            @(negedge prog_clk);
        chk("reset_point", 64'(shift_count), 64'd30);
        #2 prog_reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge prog_clk);
        prog_reset = 1'b0;
        exp_q.delete();

        // A start pulse while busy must not restart the load
        do_start();
        send_word(16'h1234, WW, 0);
        held  = shift_count;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk("start_ignored_count", 64'(shift_count), 64'(held) + 64'd1);
        chk("start_ignored_busy", 64'(busy), 64'd1);
        send_word(16'hBEEF, WW, 0);
        send_word(16'h00CD, CL % WW, 0);
        wait_idle(300);
        check_end(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
